// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and iteration count shared by muldiv_iter and the HI/LO stage
package muldiv_pkg;
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam int ITER = 32;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
endpackage

// File: rtl/muldiv_negate.sv
// muldiv_negate: two's-complement conditional negate
//   neg : negate when high
//   a   : input value
//   y   : neg ? -a : a
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);
  assign y = neg ? -a : a;
endmodule

// File: rtl/muldiv_iter.sv
// muldiv_iter: 32-iteration shift-add multiplier / restoring divider feeding the HI/LO stage
//   clk, rst_n : clock, async active-low reset
//   start, op  : request and op code (000 mult, 001 multu, 010 div, 011 divu)
//   DA, DB     : rs / rt operands, sampled with start
//   flush      : synchronous abort to IDLE, results untouched
//   busy, done : op in flight / one-cycle result strobe
//   res_hi     : product[63:32] or remainder
//   res_lo     : product[31:0] or quotient
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] DA,
  input  logic [WIDTH-1:0] DB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);
  localparam int CW = $clog2(ITER);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, prod, mul_next, div_next;
  logic [WIDTH-1:0] m, mag_a, mag_b, quo, rem;
  logic [WIDTH:0] sum;
  logic [WIDTH+1:0] diff;
  logic is_div, sgn, sa, sb, dz, accept;
  assign accept = (state == S_IDLE) && start && !op[2] && !flush;
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  muldiv_negate #(.W(WIDTH)) u_mag_a (.neg(~op[0] & DA[WIDTH-1]), .a(DA), .y(mag_a));
  muldiv_negate #(.W(WIDTH)) u_mag_b (.neg(~op[0] & DB[WIDTH-1]), .a(DB), .y(mag_b));
  muldiv_negate #(.W(2*WIDTH)) u_prod (.neg(sgn & (sa ^ sb)), .a(acc), .y(prod));
  muldiv_negate #(.W(WIDTH)) u_quo (.neg(sgn & (sa ^ sb)), .a(acc[WIDTH-1:0]), .y(quo));
  // With a zero divisor every trial subtract succeeds, so the remainder ends as |DA|
  // and negating it by sa restores the raw DA required for divide by zero.
  muldiv_negate #(.W(WIDTH)) u_rem (.neg(sgn & sa), .a(acc[2*WIDTH-1:WIDTH]), .y(rem));
  // Multiply: the adder carry lands in bit 63 as the accumulator shifts right.
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
  assign mul_next = {sum, acc[WIDTH-1:1]};
  // Divide: remainder lives in the upper half, quotient bits shift in at the bottom.
  assign diff = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, m};
  assign div_next = diff[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0}
                                  : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  always_comb begin
    state_n = state;
    state_n = flush               ? S_IDLE :
              (state == S_IDLE)   ? (accept ? S_CALC : S_IDLE) :
              (state == S_CALC)   ? ((cnt == '0) ? S_FIX : S_CALC) :
              (state == S_FIX)    ? S_DONE : S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      m      <= '0;
      is_div <= 1'b0;
      sgn    <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      dz     <= 1'b0;
      res_hi <= '0;
      res_lo <= '0;
    end else if (accept) begin
      cnt    <= CW'(ITER - 1);
      is_div <= op[1];
      sgn    <= ~op[0];
      sa     <= ~op[0] & DA[WIDTH-1];
      sb     <= ~op[0] & DB[WIDTH-1];
      dz     <= op[1] && (DB == '0);
      m      <= op[1] ? mag_b : mag_a;
      acc    <= {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
    end else if (!flush && state == S_CALC) begin
      cnt <= cnt - 1'b1;
      acc <= is_div ? div_next : mul_next;
    end else if (!flush && state == S_FIX) begin
      res_hi <= is_div ? rem : prod[2*WIDTH-1:WIDTH];
      res_lo <= dz ? '1 : is_div ? quo : prod[WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: randomized self-checking bench for muldiv_iter against an arithmetic model
module tb_muldiv_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic flush = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] da = '0, db = '0;
  logic busy, done;
  logic [31:0] res_hi, res_lo;
  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] last = '0;

  muldiv_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .DA(da), .DB(db),
    .flush(flush), .busy(busy), .done(done), .res_hi(res_hi), .res_lo(res_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    x = longint'($signed(a));
    y = longint'($signed(b));
    if (o == 3'b000) return x * y;
    if (o == 3'b001) return {32'b0, a} * {32'b0, b};
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (o == 3'b011) return {a % b, a / b};
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // Issues one op, optionally injects a second start or a flush, and checks
  // latency, busy duration, done count and result against the model.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int start2_at, input int flush_at);
    int busy_n, done_n, done_at;
    logic [63:0] got, exp;
    bit live;
    live = !o[2] && flush_at == 0;
    exp = live ? model(o, a, b) : last;
    busy_n = 0;
    done_n = 0;
    done_at = 0;
    got = '0;
    @(negedge clk);
    start = 1'b1;
    op = o;
    da = a;
    db = b;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at == 0) begin
          done_at = c;
          got = {res_hi, res_lo};
        end
      end
      if (c == start2_at) begin
        start = 1'b1;
        op = o ^ 3'b001;
        da = ~a;
        db = b + 32'd3;
      end
      if (c == flush_at) flush = 1'b1;
    end
    chk({tag, " done_n"}, 64'(done_n), live ? 64'd1 : 64'd0);
    chk({tag, " busy_n"}, 64'(busy_n), live ? 64'd34 : 64'(flush_at));
    if (live) begin
      chk({tag, " latency"}, 64'(done_at), 64'd34);
      chk({tag, " result"}, got, exp);
    end
    chk({tag, " held"}, {res_hi, res_lo}, exp);
    last = exp;
  endtask

  initial begin
    logic [2:0] o;
    logic [31:0] a, b;
    #23;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset res", {res_hi, res_lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mult 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 0, 0);
    chk("mult 7*-3 const", {res_hi, res_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("multu max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    chk("multu max const", {res_hi, res_lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("div -7/2", 3'b010, 32'hFFFF_FFF9, 32'd2, 0, 0);
    chk("div -7/2 const", {res_hi, res_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu -7/2", 3'b011, 32'hFFFF_FFF9, 32'd2, 0, 0);
    chk("divu -7/2 const", {res_hi, res_lo}, 64'h0000_0001_7FFF_FFFC);
    run_op("divu by 0", 3'b011, 32'd100, 32'd0, 0, 0);
    chk("divu by 0 const", {res_hi, res_lo}, 64'h0000_0064_FFFF_FFFF);
    run_op("div neg by 0", 3'b010, 32'hFFFF_FF00, 32'd0, 0, 0);
    run_op("div ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    chk("div ovf const", {res_hi, res_lo}, 64'h0000_0000_8000_0000);
    run_op("second start", 3'b000, 32'h1234_5678, 32'hFEDC_BA98, 5, 0);
    run_op("flush", 3'b001, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 10);
    run_op("op 1xx", 3'b100, 32'd5, 32'd6, 0, 0);
    run_op("after flush", 3'b011, 32'd1000, 32'd7, 0, 0);
    @(negedge clk);
    start = 1'b1;
    op = 3'b000;
    da = 32'd9;
    db = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst done", 64'(done), 64'd0);
    chk("async rst res", {res_hi, res_lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last = '0;
    run_op("post rst", 3'b010, 32'hFFFF_FC18, 32'd7, 0, 0);
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
      if ($urandom_range(0, 1) == 1) a = a >> $urandom_range(0, 31);
      run_op("rand", o, a, b, 0, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
